// File: rtl/sensor_nivel_if.sv
// Probe inputs, operator acknowledge and display-stage outputs of the tank level block.
// slave: the level block itself; master: the controller/environment driving the probes.
interface sensor_nivel_if;
    logic Sb;
    logic Sm;
    logic Sh;
    logic Erro_Ack;
    logic Nv_Critico;
    logic Nv_Baixo;
    logic Nv_Medio;
    logic Nv_Alto;
    logic ERRO;
    logic Sd;

    modport master (
        output Sb, Sm, Sh, Erro_Ack,
        input  Nv_Critico, Nv_Baixo, Nv_Medio, Nv_Alto, ERRO, Sd
    );

    modport slave (
        input  Sb, Sm, Sh, Erro_Ack,
        output Nv_Critico, Nv_Baixo, Nv_Medio, Nv_Alto, ERRO, Sd
    );
endinterface

// File: rtl/sensor_nivel.sv
// Reservoir level acquisition: probe sync/debounce, level decode, fault FSM, display select.
// Optional Sd alternation generator is compiled only when SENSOR_NIVEL_SD_ALTERNA_EN is defined.
module sensor_nivel #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned SD_PERIOD  = 1000
) (
    input logic           Clk,
    input logic           Rst_n,
    sensor_nivel_if.slave bus
);
    localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned INIT_W = $clog2(DEB_CYCLES + 3);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(DEB_CYCLES + 2);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FAULT} state_t;

    logic [2:0]        w_pin;
    logic [2:0]        r_sync1;
    logic [2:0]        r_sync2;
    logic [2:0]        r_deb;
    logic [DEB_W-1:0]  r_deb_cnt [3];
    logic              w_valid;
    logic [3:0]        w_lvl;
    state_t            r_state;
    state_t            w_next;
    logic [INIT_W-1:0] r_init_cnt;
    logic              w_init_done;
    logic [3:0]        r_lvl;
    logic              r_erro;

    // Bit order {Sh, Sm, Sb} forms the thermometer code.
    assign w_pin = {bus.Sh, bus.Sm, bus.Sb};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_pin;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_deb <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_deb[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // One-hot order {Alto, Medio, Baixo, Critico}.
    always_comb begin
        w_valid = 1'b1;
        w_lvl   = '0;
        case (r_deb)
            3'b000:  w_lvl = 4'b0001;
            3'b001:  w_lvl = 4'b0010;
            3'b011:  w_lvl = 4'b0100;
            3'b111:  w_lvl = 4'b1000;
            default: w_valid = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_init_done = (r_init_cnt == INIT_LAST);
        case (r_state)
            ST_INIT:  if (w_init_done) w_next = w_valid ? ST_RUN : ST_FAULT;
            ST_RUN:   if (!w_valid) w_next = ST_FAULT;
            ST_FAULT: if (w_valid && bus.Erro_Ack) w_next = ST_RUN;
            default:  w_next = ST_INIT;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_init_cnt <= '0;
        end else if (r_state == ST_INIT && !w_init_done) begin
            r_init_cnt <= r_init_cnt + INIT_W'(1);
        end
    end

    // Outputs follow the next state so a state change and its outputs share one edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_lvl  <= '0;
            r_erro <= 1'b0;
        end else begin
            case (w_next)
                ST_RUN: begin
                    r_lvl  <= w_lvl;
                    r_erro <= 1'b0;
                end
                ST_FAULT: begin
                    r_lvl  <= '0;
                    r_erro <= 1'b1;
                end
                default: begin
                    r_lvl  <= '0;
                    r_erro <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Nv_Critico = r_lvl[0];
    assign bus.Nv_Baixo   = r_lvl[1];
    assign bus.Nv_Medio   = r_lvl[2];
    assign bus.Nv_Alto    = r_lvl[3];
    assign bus.ERRO       = r_erro;

`ifdef SENSOR_NIVEL_SD_ALTERNA_EN
    localparam int unsigned SD_W = $clog2(SD_PERIOD);
    localparam logic [SD_W-1:0] SD_LAST = SD_W'(SD_PERIOD - 1);

    logic [SD_W-1:0] r_sd_cnt;
    logic            r_sd;

    // Held at zero outside steady RUN; the entry edge itself also holds, restarting the phase.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sd_cnt <= '0;
            r_sd     <= 1'b0;
        end else if (r_state != ST_RUN || w_next != ST_RUN) begin
            r_sd_cnt <= '0;
            r_sd     <= 1'b0;
        end else if (r_sd_cnt == SD_LAST) begin
            r_sd_cnt <= '0;
            r_sd     <= ~r_sd;
        end else begin
            r_sd_cnt <= r_sd_cnt + SD_W'(1);
        end
    end

    assign bus.Sd = r_sd;
`else
    assign bus.Sd = 1'b0;
`endif
endmodule

// File: tb/tb_sensor_nivel.sv
// Directed bench for sensor_nivel with a cycle-stamped scoreboard of expected outputs.
// Sd expectations depend on whether SENSOR_NIVEL_SD_ALTERNA_EN is defined for the build.
`timescale 1ns/1ps
module tb_sensor_nivel;
    localparam int DEB = 4;
    localparam int SDP = 8;
`ifdef SENSOR_NIVEL_SD_ALTERNA_EN
    localparam bit SD_EN = 1'b1;
`else
    localparam bit SD_EN = 1'b0;
`endif

    // Vector layout {Sd, ERRO, Alto, Medio, Baixo, Critico}
    localparam logic [3:0] L_CRIT  = 4'b0001;
    localparam logic [3:0] L_BAIXO = 4'b0010;
    localparam logic [3:0] L_MEDIO = 4'b0100;
    localparam logic [3:0] L_ALTO  = 4'b1000;
    localparam logic [5:0] V_ZERO  = 6'b000000;
    localparam logic [5:0] V_FAULT = 6'b010000;

    typedef struct {
        int         at;
        logic [5:0] exp;
        string      tag;
    } sb_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    sb_t  sb[$];

    sensor_nivel_if bus();

    sensor_nivel #(.DEB_CYCLES(DEB), .SD_PERIOD(SDP)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [5:0] obs();
        return {bus.Sd, bus.ERRO, bus.Nv_Alto, bus.Nv_Medio, bus.Nv_Baixo, bus.Nv_Critico};
    endfunction

    task automatic check(input string tag, input logic [5:0] o, input logic [5:0] e);
        n_checks++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, o, e);
        end
    endtask

    task automatic push(input int at, input logic [5:0] e, input string tag);
        sb_t item;
        item.at  = at;
        item.exp = e;
        item.tag = tag;
        sb.push_back(item);
    endtask

    task automatic exp_const(input int from, input int to, input logic [5:0] e, input string tag);
        for (int c = from; c <= to; c++) push(c, e, tag);
    endtask

    // Sd toggles every SDP edges counted from the RUN entry edge.
    task automatic exp_run(input int from, input int to, input logic [3:0] lvl,
                           input int entry, input string tag);
        logic sd;
        for (int c = from; c <= to; c++) begin
            sd = SD_EN && ((((c - entry) / SDP) % 2) == 1);
            push(c, {sd, 1'b0, lvl}, tag);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go_until(input int c);
        while (cyc < c) step(1);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < sb.size(); ) begin
            if (sb[i].at == cyc) begin
                check(sb[i].tag, obs(), sb[i].exp);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        int c0;
        int p;
        int a;
        int entry;

        bus.Sb = 1'b1;
        bus.Sm = 1'b1;
        bus.Sh = 1'b1;
        bus.Erro_Ack = 1'b0;
        step(3);
        check("reset_hold", obs(), V_ZERO);

        // Startup with probes at 111.
        c0 = cyc;
        rst_n = 1'b1;
        entry = c0 + 7;
        exp_const(c0 + 1, c0 + 6, V_ZERO, "init_quiet");
        exp_run(c0 + 7, c0 + 22, L_ALTO, entry, "startup_alto");
        go_until(c0 + 22);

        // 111 -> 011
        p = cyc;
        bus.Sh = 1'b0;
        exp_run(p + 1, p + 6, L_ALTO, entry, "to_medio_hold");
        exp_run(p + 7, p + 12, L_MEDIO, entry, "to_medio");
        go_until(p + 12);

        // Sh glitch of 3 cycles is rejected.
        p = cyc;
        exp_run(p + 1, p + 14, L_MEDIO, entry, "glitch_reject");
        bus.Sh = 1'b1;
        step(3);
        bus.Sh = 1'b0;
        go_until(p + 14);

        // Sh held: Alto exactly 7 edges after the pin change.
        p = cyc;
        bus.Sh = 1'b1;
        exp_run(p + 1, p + 6, L_MEDIO, entry, "sh_hold_pre");
        exp_run(p + 7, p + 9, L_ALTO, entry, "sh_hold_alto");
        go_until(p + 9);

        // 111 -> 001
        p = cyc;
        bus.Sh = 1'b0;
        bus.Sm = 1'b0;
        exp_run(p + 1, p + 6, L_ALTO, entry, "to_baixo_hold");
        exp_run(p + 7, p + 10, L_BAIXO, entry, "to_baixo");
        go_until(p + 10);

        // 001 -> 101 invalid
        p = cyc;
        bus.Sh = 1'b1;
        exp_run(p + 1, p + 6, L_BAIXO, entry, "to_fault_hold");
        exp_const(p + 7, p + 12, V_FAULT, "fault_101");
        go_until(p + 12);

        // Acknowledge ignored while code is invalid.
        p = cyc;
        bus.Erro_Ack = 1'b1;
        exp_const(p + 1, p + 4, V_FAULT, "ack_invalid");
        go_until(p + 4);
        bus.Erro_Ack = 1'b0;

        // 101 -> 011 with no ack: fault is sticky.
        p = cyc;
        bus.Sh = 1'b0;
        bus.Sm = 1'b1;
        exp_const(p + 1, p + 10, V_FAULT, "fault_sticky");
        go_until(p + 10);

        // Valid code plus ack: exit on the next edge.
        a = cyc;
        bus.Erro_Ack = 1'b1;
        entry = a + 1;
        exp_run(a + 1, a + 11, L_MEDIO, entry, "fault_exit");
        step(1);
        bus.Erro_Ack = 1'b0;
        go_until(a + 12);

        // Asynchronous reset mid-period while Sd is high.
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", obs(), V_ZERO);
        bus.Sh = 1'b1;
        step(2);
        check("reset_held", obs(), V_ZERO);

        c0 = cyc;
        rst_n = 1'b1;
        entry = c0 + 7;
        exp_const(c0 + 1, c0 + 6, V_ZERO, "reinit_quiet");
        exp_run(c0 + 7, c0 + 16, L_ALTO, entry, "reinit_alto");
        go_until(c0 + 16);

        // Ack in RUN has no effect; invalid code with ack still faults.
        p = cyc;
        bus.Erro_Ack = 1'b1;
        bus.Sb = 1'b0;
        exp_run(p + 1, p + 6, L_ALTO, entry, "ack_in_run");
        exp_const(p + 7, p + 12, V_FAULT, "fault_wins");
        go_until(p + 12);
        bus.Erro_Ack = 1'b0;

        for (int k = 0; k < 50 && sb.size() > 0; k++) step(1);
        n_checks++;
        assert (sb.size() == 0) n_pass++;
        else begin
            n_fail++;
            $error("FAIL scoreboard_drained: observed %0d pending expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
